// File: rtl/tea_io_mailbox.sv
// tea_io_mailbox: byte-stream mailbox between the tea_cpu IO bus and an
// external host. The host pushes bytes into an RX FIFO that the CPU drains
// through the DATA register. The CPU pushes bytes into a TX FIFO that the
// host drains. The block decodes a 4-register window of the 32-entry IO space.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   io_addr    CPU IO address (5 bits)
//   io_rd      CPU IO read strobe, high for 2 clocks per access
//   io_wr      CPU IO write strobe, high for 2 clocks per access
//   io_wrdata  CPU write data
//   io_rddata  registered read data, loaded on the first cycle of a read
//   rx_data    host->CPU byte
//   rx_valid   host byte valid
//   rx_ready   RX FIFO can accept a byte
//   tx_data    TX FIFO head (show-ahead)
//   tx_valid   TX FIFO non-empty
//   tx_ready   host accepts tx_data
//
// Register map (offset io_addr[1:0]):
//   0 DATA    read pops RX (00 + rx_underflow if empty);
//             write pushes TX (dropped + tx_overflow if full)
//   1 STATUS  {2'b0, tx_overflow, rx_underflow, tx_empty, tx_full,
//              rx_full, rx_nonempty}; write-1-to-clear bits 5 and 4
//   2 RXCOUNT RX occupancy, read-only
//   3 TXCOUNT TX occupancy, read-only
//
// Host handshakes: a byte moves on a clock edge where valid and ready are
// both high. valid does not depend on ready; ready/valid driven by this
// block are functions of registered counts only, so they are stable for the
// whole cycle.
module tea_io_mailbox #(
    parameter logic [4:0] BASE_ADDR   = 5'h10,
    parameter int         DEPTH_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int CW    = DEPTH_WIDTH + 1;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    logic [DEPTH_WIDTH-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0]          rx_count, tx_count;
    logic                   rx_underflow, tx_overflow;
    logic                   rd_d, wr_d;

    // Status derived from the counts registered at the start of the cycle.
    // A count can only reach DEPTH = 2^DEPTH_WIDTH with its top bit set.
    logic rx_full, rx_empty, tx_full, tx_empty;
    assign rx_full  = rx_count[DEPTH_WIDTH];
    assign tx_full  = tx_count[DEPTH_WIDTH];
    assign rx_empty = (rx_count == '0);
    assign tx_empty = (tx_count == '0);

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr];

    // Each 2-clock access acts once, on its first cycle.
    logic       in_win, rd_start, wr_start;
    logic [1:0] off;
    assign in_win   = (io_addr[4:2] == BASE_ADDR[4:2]);
    assign off      = io_addr[1:0];
    assign rd_start = io_rd & ~rd_d & in_win;
    assign wr_start = io_wr & ~wr_d & in_win;

    logic data_rd, data_wr, status_wr;
    assign data_rd   = rd_start && (off == 2'd0);
    assign data_wr   = wr_start && (off == 2'd0);
    assign status_wr = wr_start && (off == 2'd1);

    logic rx_push, rx_pop, tx_push, tx_pop;
    assign rx_push = rx_valid && rx_ready;
    assign rx_pop  = data_rd && !rx_empty;
    assign tx_push = data_wr && !tx_full;
    assign tx_pop  = tx_valid && tx_ready;

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        case (off)
            2'd0:    rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
            2'd1:    rd_mux = {2'b00, tx_overflow, rx_underflow,
                               tx_empty, tx_full, rx_full, !rx_empty};
            2'd2:    rd_mux = 8'(rx_count);
            default: rd_mux = 8'(tx_count);
        endcase
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= io_wrdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d         <= 1'b0;
            wr_d         <= 1'b0;
            io_rddata    <= 8'h00;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            rx_count     <= '0;
            tx_count     <= '0;
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rd_d <= io_rd;
            wr_d <= io_wr;

            if (rd_start) io_rddata <= rd_mux;

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + DEPTH_WIDTH'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + DEPTH_WIDTH'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + DEPTH_WIDTH'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + DEPTH_WIDTH'(1);

            // Simultaneous push and pop leaves the count unchanged.
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase

            // Set and W1C cannot coincide: an access is a read or a write.
            if (data_rd && rx_empty)
                rx_underflow <= 1'b1;
            else if (status_wr && io_wrdata[4])
                rx_underflow <= 1'b0;

            if (data_wr && tx_full)
                tx_overflow <= 1'b1;
            else if (status_wr && io_wrdata[5])
                tx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tea_io_mailbox.sv
// Bench for tea_io_mailbox: a vector table of CPU/host operations for the
// basic register behaviour, followed by hand-written sequences for the FIFO
// fill/drain, pointer wrap, simultaneous events, window decode and reset.
module tb_tea_io_mailbox;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] io_addr;
    logic       io_rd, io_wr;
    logic [7:0] io_wrdata, io_rddata;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    tea_io_mailbox #(.BASE_ADDR(5'h10), .DEPTH_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wrdata(io_wrdata), .io_rddata(io_rddata),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // ---------------- drivers (enter and leave at posedge+1) ----------------
    task automatic cpu_read(input logic [4:0] a, output logic [7:0] d);
        io_addr = a;
        io_rd   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 d  = io_rddata;
        io_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] v);
        io_addr   = a;
        io_wrdata = v;
        io_wr     = 1'b1;
        repeat (2) @(posedge clk);
        #1 io_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [7:0] d);
        bit done;
        done     = 1'b0;
        rx_data  = d;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (done) rx_q.push_back(d);
        else check("host_push_timeout", 8'h00, 8'h01);
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] d;
        cpu_read(a, d);
        check(name, d, exp);
    endtask

    // Pops the RX scoreboard and compares against a DATA read.
    task automatic read_data_sb(input string name);
        logic [7:0] d;
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        cpu_read(5'h10, d);
        check(name, d, exp);
    endtask

    // ---------------- vector table ----------------
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_PUSH} op_t;
    typedef struct {
        op_t        op;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    initial begin
        logic [7:0] d;
        int         budget;

        tbl[0]  = '{OP_RD,   5'h11, 8'h00, 8'h08};  // STATUS after reset: tx_empty
        tbl[1]  = '{OP_RD,   5'h12, 8'h00, 8'h00};
        tbl[2]  = '{OP_RD,   5'h13, 8'h00, 8'h00};
        tbl[3]  = '{OP_PUSH, 5'h00, 8'hA5, 8'h00};
        tbl[4]  = '{OP_PUSH, 5'h00, 8'h3C, 8'h00};
        tbl[5]  = '{OP_RD,   5'h12, 8'h00, 8'h02};
        tbl[6]  = '{OP_RD,   5'h10, 8'h00, 8'hA5};
        tbl[7]  = '{OP_RD,   5'h12, 8'h00, 8'h01};
        tbl[8]  = '{OP_RD,   5'h10, 8'h00, 8'h3C};
        tbl[9]  = '{OP_RD,   5'h12, 8'h00, 8'h00};
        tbl[10] = '{OP_RD,   5'h10, 8'h00, 8'h00};  // empty read
        tbl[11] = '{OP_RD,   5'h11, 8'h00, 8'h18};  // rx_underflow set
        tbl[12] = '{OP_WR,   5'h11, 8'h10, 8'h00};  // W1C rx_underflow
        tbl[13] = '{OP_RD,   5'h11, 8'h00, 8'h08};
        tbl[14] = '{OP_WR,   5'h12, 8'hFF, 8'h00};  // RXCOUNT is read-only
        tbl[15] = '{OP_RD,   5'h12, 8'h00, 8'h00};

        // ---------------- reset ----------------
        rst = 1'b1; io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wrdata = '0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("reset_io_rddata", io_rddata, 8'h00);

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            case (tbl[i].op)
                OP_RD: begin
                    cpu_read(tbl[i].addr, d);
                    check($sformatf("tbl%0d_rd_%02h", i, tbl[i].addr), d, tbl[i].exp);
                end
                OP_WR:   cpu_write(tbl[i].addr, tbl[i].data);
                default: host_push(tbl[i].data);
            endcase
        end
        rx_q.delete();  // table pushes were checked against table values

        // ---------------- TX fill with overflow, then drain ----------------
        for (int i = 1; i <= 9; i++) begin
            if (tx_q.size() < 8) tx_q.push_back(8'(i));
            cpu_write(5'h10, 8'(i));
        end
        read_check("tx_count_full", 5'h13, 8'h08);
        read_check("status_tx_full_ovf", 5'h11, 8'h24);
        check("tx_valid_full", {7'b0, tx_valid}, 8'h01);

        tx_ready = 1'b1;
        budget = 0;
        while (tx_q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
            if (tx_valid) check($sformatf("tx_drain_%0d", budget), tx_data, tx_q.pop_front());
        end
        if (tx_q.size() != 0) check("tx_drain_timeout", 8'h00, 8'h01);
        @(negedge clk);
        check("tx_valid_after_drain", {7'b0, tx_valid}, 8'h00);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        cpu_write(5'h11, 8'h20);
        read_check("status_ovf_cleared", 5'h11, 8'h08);

        // ---------------- RX fill, hold-off, wrap ----------------
        for (int i = 0; i < 8; i++) host_push(8'h40 + 8'(i));
        rx_data  = 8'h48;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rx_ready_held_%0d", i), {7'b0, rx_ready}, 8'h00);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
        read_check("rx_count_full", 5'h12, 8'h08);
        read_check("status_rx_full", 5'h11, 8'h0B);
        read_data_sb("rx_pop_first");

        // CPU DATA read and host push in the same cycle at count 7.
        io_addr  = 5'h10;
        io_rd    = 1'b1;
        rx_data  = 8'h50;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1 d  = io_rddata;
        io_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rd_push_same_cycle", d, rx_q.pop_front());
        rx_q.push_back(8'h50);
        read_check("rx_count_still_7", 5'h12, 8'h07);
        for (int i = 0; i < 7; i++) read_data_sb($sformatf("rx_wrap_%0d", i));
        read_check("status_rx_drained", 5'h11, 8'h08);

        // ---------------- outside the window ----------------
        read_check("oow_rd_04_unchanged", 5'h04, 8'h08);
        read_check("oow_rd_06_unchanged", 5'h06, 8'h08);
        cpu_write(5'h04, 8'hFF);
        cpu_write(5'h05, 8'h30);
        check("oow_wr_no_tx", {7'b0, tx_valid}, 8'h00);
        read_check("oow_status", 5'h11, 8'h08);

        // ---------------- reset in the middle of a write ----------------
        cpu_write(5'h10, 8'hAA);
        host_push(8'h77);
        cpu_read(5'h10, d);
        cpu_read(5'h10, d);  // empty: sets rx_underflow
        io_addr   = 5'h10;
        io_wrdata = 8'hBB;
        io_wr     = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        io_wr = 1'b0;
        rx_q.delete();
        tx_q.delete();
        check("rst_mid_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("rst_mid_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_mid_io_rddata", io_rddata, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        read_check("rst_mid_status", 5'h11, 8'h08);
        read_check("rst_mid_rxcount", 5'h12, 8'h00);

        // io_wr held through reset is a fresh access on the first cycle after.
        io_addr   = 5'h10;
        io_wrdata = 8'hCC;
        io_wr     = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 io_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_wr_valid", {7'b0, tx_valid}, 8'h01);
        check("post_rst_wr_data", tx_data, 8'hCC);
        read_check("post_rst_txcount", 5'h13, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
